// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// The pipeline side (master) raises requests; the controller (slave) answers with holds, flushes and status.
interface pipe_ctrl_if #(
  parameter int EXCNT_W = 6,
  parameter int PERF_W  = 16
) ();
  logic               stallreq_if;
  logic               stallreq_id;
  logic               ex_start;
  logic [EXCNT_W-1:0] ex_cycles;
  logic               stallreq_mem;
  logic               excp_valid;
  logic [31:0]        excp_handler;
  logic               eret_valid;
  logic [31:0]        epc;
  logic [5:0]         stall;
  logic               flush;
  logic [31:0]        new_pc;
  logic               ex_busy;
  logic               ex_done;
  logic [PERF_W-1:0]  stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, ex_start, ex_cycles, stallreq_mem,
           excp_valid, excp_handler, eret_valid, epc,
    input  stall, flush, new_pc, ex_busy, ex_done, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, ex_start, ex_cycles, stallreq_mem,
           excp_valid, excp_handler, eret_valid, epc,
    output stall, flush, new_pc, ex_busy, ex_done, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage core: prioritises hold requests, sequences
// multi-cycle EX operations, redirects on exception/eret and counts stalled cycles.
module pipe_ctrl #(
  parameter int EXCNT_W = 6,
  parameter int PERF_W  = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_IF  = 6'b000011;

  state_t             state, state_nxt;
  logic [EXCNT_W-1:0] cnt, cnt_nxt;
  logic [PERF_W-1:0]  perf;
  logic               exstall;
  logic               done_raw;
  logic               flush_req;
  logic [5:0]         stall_c;
  logic               flush_c;
  logic [31:0]        new_pc_c;
  logic               done_c;

  assign flush_req = bus.excp_valid | bus.eret_valid;

  // cnt holds the stall cycles still owed by the op in flight, including the current one
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exstall   = 1'b0;
    done_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ex_start) begin
          if (bus.ex_cycles >= EXCNT_W'(2)) begin
            exstall   = 1'b1;
            state_nxt = BUSY;
            cnt_nxt   = bus.ex_cycles - EXCNT_W'(1);
          end else if (bus.ex_cycles == EXCNT_W'(1)) begin
            exstall  = 1'b1;
            done_raw = 1'b1;
          end
        end
      end
      BUSY: begin
        exstall  = 1'b1;
        done_raw = (cnt == EXCNT_W'(1));
        cnt_nxt  = cnt - EXCNT_W'(1);
        if (done_raw) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_req) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    stall_c  = '0;
    flush_c  = 1'b0;
    new_pc_c = '0;
    done_c   = 1'b0;
    if (!rst) begin
      if (flush_req) begin
        flush_c  = 1'b1;
        new_pc_c = bus.excp_valid ? bus.excp_handler : bus.epc;
      end else begin
        done_c = done_raw;
        if (bus.stallreq_mem)     stall_c = STALL_MEM;
        else if (exstall)         stall_c = STALL_EX;
        else if (bus.stallreq_id) stall_c = STALL_ID;
        else if (bus.stallreq_if) stall_c = STALL_IF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      perf  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_c[0] && (perf != '1)) perf <= perf + PERF_W'(1);
    end
  end

  assign bus.stall        = stall_c;
  assign bus.flush        = flush_c;
  assign bus.new_pc       = new_pc_c;
  assign bus.ex_done      = done_c;
  assign bus.ex_busy      = !rst && (state == BUSY);
  assign bus.stall_cycles = perf;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, both scored against
// a remaining-cycles reference model; a second instance with a 4-bit counter covers saturation.
module tb_pipe_ctrl;

  localparam int EXCNT_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.EXCNT_W(EXCNT_W), .PERF_W(16)) if0 ();
  pipe_ctrl_if #(.EXCNT_W(EXCNT_W), .PERF_W(4))  if1 ();

  pipe_ctrl #(.EXCNT_W(EXCNT_W), .PERF_W(16)) dut (.clk(clk), .rst(rst), .bus(if0.slave));
  pipe_ctrl #(.EXCNT_W(EXCNT_W), .PERF_W(4))  dut_s (.clk(clk), .rst(rst), .bus(if1.slave));

  assign if1.stallreq_if  = if0.stallreq_if;
  assign if1.stallreq_id  = if0.stallreq_id;
  assign if1.ex_start     = if0.ex_start;
  assign if1.ex_cycles    = if0.ex_cycles;
  assign if1.stallreq_mem = if0.stallreq_mem;
  assign if1.excp_valid   = if0.excp_valid;
  assign if1.excp_handler = if0.excp_handler;
  assign if1.eret_valid   = if0.eret_valid;
  assign if1.epc          = if0.epc;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: stall cycles still owed by the EX op, and the two perf counters
  int m_rem    = 0;
  int m_perf16 = 0;
  int m_perf4  = 0;
  int rem_n;
  logic [5:0]  e_stall;
  logic        e_flush, e_busy, e_done;
  logic [31:0] e_newpc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    int   left;
    logic exst;
    e_stall = '0; e_flush = 1'b0; e_newpc = '0; e_busy = 1'b0; e_done = 1'b0;
    rem_n   = 0;
    left    = 0;
    exst    = 1'b0;
    if (!rst) begin
      e_busy = (m_rem > 0);
      if (m_rem > 0) begin
        exst = 1'b1; left = m_rem;
      end else if (if0.ex_start && int'(if0.ex_cycles) >= 1) begin
        exst = 1'b1; left = int'(if0.ex_cycles);
      end
      rem_n  = exst ? left - 1 : 0;
      e_done = exst && (left == 1);
      if (if0.excp_valid || if0.eret_valid) begin
        e_flush = 1'b1;
        e_newpc = if0.excp_valid ? if0.excp_handler : if0.epc;
        e_done  = 1'b0;
        rem_n   = 0;
      end else if (if0.stallreq_mem) e_stall = 6'b011111;
      else if (exst)                 e_stall = 6'b001111;
      else if (if0.stallreq_id)      e_stall = 6'b000111;
      else if (if0.stallreq_if)      e_stall = 6'b000011;
    end
  endtask

  task automatic cycle();
    #2;
    model_eval();
    chk("stall",   64'(if0.stall),   64'(e_stall));
    chk("flush",   64'(if0.flush),   64'(e_flush));
    chk("new_pc",  64'(if0.new_pc),  64'(e_newpc));
    chk("ex_busy", 64'(if0.ex_busy), 64'(e_busy));
    chk("ex_done", 64'(if0.ex_done), 64'(e_done));
    chk("stall_s", 64'(if1.stall),   64'(e_stall));
    @(posedge clk);
    if (rst) begin
      m_rem = 0; m_perf16 = 0; m_perf4 = 0;
    end else begin
      m_rem = rem_n;
      if (e_stall[0]) begin
        if (m_perf16 < 65535) m_perf16++;
        if (m_perf4 < 15)     m_perf4++;
      end
    end
    #1;
    chk("stall_cycles",   64'(if0.stall_cycles), 64'(m_perf16));
    chk("stall_cycles_s", 64'(if1.stall_cycles), 64'(m_perf4));
  endtask

  task automatic idle_inputs();
    if0.stallreq_if = 1'b0; if0.stallreq_id = 1'b0; if0.stallreq_mem = 1'b0;
    if0.ex_start = 1'b0; if0.ex_cycles = '0;
    if0.excp_valid = 1'b0; if0.eret_valid = 1'b0;
    if0.excp_handler = 32'hBFC00380; if0.epc = 32'h80001000;
  endtask

  task automatic start_op(input int n);
    if0.ex_start  = 1'b1;
    if0.ex_cycles = EXCNT_W'(n);
    cycle();
    if0.ex_start  = 1'b0;
    if0.ex_cycles = '0;
  endtask

  initial begin
    idle_inputs();
    // Reset with every request high
    rst = 1'b1;
    if0.stallreq_if = 1'b1; if0.stallreq_id = 1'b1; if0.stallreq_mem = 1'b1;
    if0.ex_start = 1'b1; if0.ex_cycles = EXCNT_W'(5);
    if0.excp_valid = 1'b1; if0.eret_valid = 1'b1;
    cycle();
    cycle();
    chk("rst_stall",  64'(if0.stall),  64'd0);
    chk("rst_new_pc", 64'(if0.new_pc), 64'd0);
    rst = 1'b0;
    idle_inputs();
    cycle();

    // Divide: 4 stall cycles, done in the last
    start_op(4);
    for (int i = 0; i < 3; i++) cycle();
    chk("div_perf", 64'(if0.stall_cycles), 64'd4);
    cycle();

    // Request priority
    if0.stallreq_if = 1'b1; if0.stallreq_id = 1'b1; if0.stallreq_mem = 1'b1;
    cycle();
    if0.stallreq_mem = 1'b0;
    cycle();
    if0.stallreq_id = 1'b0;
    cycle();
    idle_inputs();

    // Exception in BUSY cycle 3 of a 10-cycle op
    start_op(10);
    cycle();
    if0.excp_valid = 1'b1;
    #2;
    chk("excp_new_pc", 64'(if0.new_pc), 64'hBFC00380);
    cycle();
    if0.excp_valid = 1'b0;
    cycle();
    cycle();

    // Exception plus eret, then eret alone
    if0.excp_valid = 1'b1; if0.eret_valid = 1'b1;
    cycle();
    if0.excp_valid = 1'b0;
    #2;
    chk("eret_new_pc", 64'(if0.new_pc), 64'h80001000);
    cycle();
    idle_inputs();
    cycle();

    // Exception on the ex_done cycle, and ex_start under flush
    start_op(3);
    cycle();
    if0.excp_valid = 1'b1;
    cycle();
    if0.ex_start = 1'b1; if0.ex_cycles = EXCNT_W'(5);
    cycle();
    idle_inputs();
    cycle();

    // Single-cycle and zero-length ops, ex_start ignored while BUSY, MEM stall over BUSY
    start_op(1);
    start_op(0);
    start_op(5);
    if0.ex_start = 1'b1; if0.ex_cycles = EXCNT_W'(9);
    cycle();
    if0.ex_start = 1'b0; if0.stallreq_mem = 1'b1;
    cycle();
    cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();

    // Reset in the middle of a long op
    start_op(20);
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle(); cycle();

    // Maximum-length op
    start_op(63);
    for (int i = 0; i < 64; i++) cycle();

    // Saturation of the 4-bit counter
    if0.stallreq_if = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_perf4", 64'(if1.stall_cycles), 64'd15);
    idle_inputs();
    cycle();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst               = ($urandom_range(0, 199) == 0);
      if0.stallreq_if   = ($urandom_range(0, 3) == 0);
      if0.stallreq_id   = ($urandom_range(0, 4) == 0);
      if0.stallreq_mem  = ($urandom_range(0, 6) == 0);
      if0.excp_valid    = ($urandom_range(0, 24) == 0);
      if0.eret_valid    = ($urandom_range(0, 29) == 0);
      if0.excp_handler  = $urandom;
      if0.epc           = $urandom;
      if0.ex_start      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) if0.ex_cycles = EXCNT_W'($urandom);
      else                            if0.ex_cycles = EXCNT_W'($urandom_range(0, 8));
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the 5-stage core. It collects stall requests from IF, ID, EX and MEM and drives the per-stage `stall` vector consumed by the PC register and the stage registers (if_id, id_ex, ex_mem, mem_wb). It sequences multi-cycle EX operations (mult/div) with an internal down-counter. On an exception or eret it flushes the pipeline and supplies the redirect PC. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `EXCNT_W`, default 6: width of the EX multi-cycle count.
- `PERF_W`, default 16: width of the stall-cycle performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1).
- `stallreq_if`  in  1  instruction fetch bus not ready.
- `stallreq_id`  in  1  load-use hazard detected in ID.
- `ex_start`  in  1  EX begins a multi-cycle operation this cycle.
- `ex_cycles`  in  EXCNT_W  total stall cycles the operation needs; sampled only with `ex_start`.
- `stallreq_mem`  in  1  data bus not ready.
- `excp_valid`  in  1  exception committed in MEM.
- `excp_handler`  in  32  handler address.
- `eret_valid`  in  1  eret committed in MEM.
- `epc`  in  32  return address for eret.
- `stall`  out  6  hold enables; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush`  out  1  clear all stage registers.
- `new_pc`  out  32  redirect target, valid when `flush` = 1.
- `ex_busy`  out  1  EX sequencer is in BUSY.
- `ex_done`  out  1  last stall cycle of a multi-cycle op; EX latches its result.
- `stall_cycles`  out  PERF_W  count of cycles with `stall[0]` = 1.

## Operation
EX sequencer FSM has two states, IDLE and BUSY, plus counter `cnt`.
- IDLE, `ex_start` = 1 and `ex_cycles` = N ≥ 2: `exstall` = 1 this cycle; next state BUSY with `cnt` = N−1.
- IDLE, `ex_start` = 1 and N = 1: `exstall` = 1 and `ex_done` = 1 this cycle; stay in IDLE.
- IDLE, `ex_start` = 1 and N = 0: treated as a single-cycle op; no stall, no `ex_done`.
- BUSY: `exstall` = 1 every cycle. `ex_done` = (`cnt` = 1). `cnt` decrements each cycle. When `cnt` = 1, next state is IDLE.
- BUSY ignores `ex_start`.
- BUSY keeps counting while MEM stalls; the EX unit runs independently of the pipeline hold.
- Result: an op with N ≥ 1 produces exactly N consecutive `exstall` cycles, and `ex_done` is high in the last of them.

Output priority, evaluated combinationally every cycle (highest first):
1. `excp_valid` or `eret_valid`: `stall` = 000000, `flush` = 1. `new_pc` = `excp_handler` if `excp_valid`, else `epc`; exception wins when both are set. Next state IDLE, `cnt` = 0. `ex_done` is forced to 0.
2. `stallreq_mem`: `stall` = 011111.
3. `exstall`: `stall` = 001111.
4. `stallreq_id`: `stall` = 000111.
5. `stallreq_if`: `stall` = 000011.
6. Otherwise: `stall` = 000000.

Whenever `flush` = 0, `new_pc` = 0.

`ex_busy` = (state = BUSY).

`stall_cycles` increments by 1 on each clock edge where `stall[0]` = 1 and `rst` = 0. It saturates at all-ones and is cleared only by reset.

## Timing
- `stall`, `flush`, `new_pc` and `ex_done` are combinational from the inputs and current state, with zero latency. The pipeline registers act on them at the same edge.
- FSM state, `cnt` and `stall_cycles` are registered.
- Reset (synchronous): state IDLE, `cnt` = 0, `stall_cycles` = 0. While `rst` = 1, all combinational outputs are forced to 0 regardless of inputs: `stall` = 0, `flush` = 0, `new_pc` = 0, `ex_busy` = 0, `ex_done` = 0.
- Reset asserted mid-BUSY aborts the operation; the cycle after reset deasserts starts in IDLE.
- An exception in any BUSY cycle, including the `ex_done` cycle, aborts the operation with no `ex_done`.
- An `ex_start` in the same cycle as a flush is ignored.
- Simultaneous requests resolve strictly by the priority list above.
- `ex_cycles` uses unsigned arithmetic in EXCNT_W bits; the maximum N is 2^EXCNT_W − 1.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with all requests high → `stall` = 0, `flush` = 0, `new_pc` = 0, `stall_cycles` = 0; after release, IDLE.
- Divide: `ex_start` = 1 with `ex_cycles` = 4 for one cycle → `stall` = 001111 for exactly 4 cycles, `ex_busy` high for cycles 2–4, `ex_done` only in cycle 4, then `stall` = 0; `stall_cycles` = 4.
- Priority: `stallreq_if`, `stallreq_id` and `stallreq_mem` all high → 011111. Drop `stallreq_mem` → 000111. Drop `stallreq_id` → 000011.
- Exception abort: `ex_cycles` = 10; assert `excp_valid` with `excp_handler` = 0xBFC00380 in BUSY cycle 3 → `flush` = 1, `stall` = 0, `new_pc` = 0xBFC00380 that cycle; next cycle IDLE, `ex_busy` = 0; `ex_done` never asserted.
- Exception plus eret same cycle, with `epc` = 0x80001000 → `new_pc` = handler. eret alone → `new_pc` = 0x80001000 for one cycle.
- Saturation: with PERF_W overridden to 4, hold `stallreq_if` for 20 cycles → `stall_cycles` stops at 15.
